// File: rtl/multicycle_control_pkg.sv
// Shared constants and state encoding for the multi-cycle control sequencer.
package multicycle_pkg;

    localparam int unsigned OPC_W    = 2;
    localparam int unsigned F2_W     = 2;
    localparam int unsigned ALU_OP_W = 2;
    localparam int unsigned STATE_W  = 3;

    localparam logic [OPC_W-1:0] OP_R = 2'b00;
    localparam logic [OPC_W-1:0] OP_I = 2'b01;
    localparam logic [OPC_W-1:0] OP_S = 2'b10;
    localparam logic [OPC_W-1:0] OP_B = 2'b11;

    localparam logic [F2_W-1:0] F2_LOAD  = 2'b01;
    localparam logic [F2_W-1:0] F2_STORE = 2'b00;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory bundle.
//   master: the sequencer (drives enables/selects, reads instr/ready/branch).
//   slave : the datapath/memory side.
interface multicycle_control_if #(
    parameter int unsigned INSTR_W = 16
);
    logic [INSTR_W-1:0]                 instr_in;
    logic                               mem_ready;
    logic                               branch_taken;
    logic                               mem_req;
    logic                               mem_write;
    logic                               addr_sel;
    logic                               ir_write;
    logic                               pc_write;
    logic                               pc_src;
    logic                               alu_src;
    logic [multicycle_pkg::ALU_OP_W-1:0] alu_op;
    logic                               reg_write;
    logic                               mem_to_reg;
    logic                               fault;
    logic [multicycle_pkg::STATE_W-1:0]  state;

    modport master (
        input  instr_in, mem_ready, branch_taken,
        output mem_req, mem_write, addr_sel, ir_write, pc_write, pc_src,
               alu_src, alu_op, reg_write, mem_to_reg, fault, state
    );

    modport slave (
        output instr_in, mem_ready, branch_taken,
        input  mem_req, mem_write, addr_sel, ir_write, pc_write, pc_src,
               alu_src, alu_op, reg_write, mem_to_reg, fault, state
    );
endinterface

// File: rtl/multicycle_control_instr_class_decode.sv
// Combinational instruction-class decode of the latched opcode/funct2.
// Ports: i_opcode, i_funct2 in; o_is_* class flags, o_alu_src, o_alu_op out.
module instr_class_decode
    import multicycle_pkg::*;
(
    input  logic [OPC_W-1:0]    i_opcode,
    input  logic [F2_W-1:0]     i_funct2,
    output logic                o_is_rtype,
    output logic                o_is_load,
    output logic                o_is_itype,
    output logic                o_is_store,
    output logic                o_is_branch,
    output logic                o_alu_src,
    output logic [ALU_OP_W-1:0] o_alu_op
);
    always_comb begin
        o_is_rtype  = (i_opcode == OP_R);
        o_is_load   = (i_opcode == OP_I) && (i_funct2 == F2_LOAD);
        o_is_itype  = (i_opcode == OP_I) && (i_funct2 != F2_LOAD);
        o_is_store  = (i_opcode == OP_S) && (i_funct2 == F2_STORE);
        o_is_branch = (i_opcode == OP_B);
        o_alu_src   = (i_opcode == OP_I) || (i_opcode == OP_S);
        // Loads compute an address, so force ADD regardless of funct2.
        o_alu_op    = o_is_load ? ALU_OP_W'(0) : ALU_OP_W'(i_funct2);
    end
endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK over one shared
// memory port, with a request timeout watchdog that parks in FAULT.
// Ports: clk, rst (sync, active-high); bus (master modport) carries the
// instruction/ready/branch inputs and all datapath control outputs.
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int unsigned INSTR_W     = 16,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned TO_W        = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.master bus
);
    state_t                r_state;
    state_t                w_next;
    logic [OPC_W-1:0]      r_opcode;
    logic [F2_W-1:0]       r_funct2;
    logic [TO_W-1:0]       r_cnt;
    logic                  r_fault;

    logic                  w_is_rtype, w_is_load, w_is_itype, w_is_store, w_is_branch;
    logic                  w_dec_alu_src;
    logic [ALU_OP_W-1:0]   w_dec_alu_op;
    logic                  w_to_hit;
    logic                  w_unused_instr;

    logic                  w_mem_req, w_mem_write, w_addr_sel, w_ir_write, w_pc_write;
    logic                  w_pc_src, w_alu_src, w_reg_write, w_mem_to_reg;
    logic [ALU_OP_W-1:0]   w_alu_op;

    assign w_unused_instr = ^{bus.instr_in[INSTR_W-1:8], bus.instr_in[5:2]};

    instr_class_decode u_dec (
        .i_opcode    (r_opcode),
        .i_funct2    (r_funct2),
        .o_is_rtype  (w_is_rtype),
        .o_is_load   (w_is_load),
        .o_is_itype  (w_is_itype),
        .o_is_store  (w_is_store),
        .o_is_branch (w_is_branch),
        .o_alu_src   (w_dec_alu_src),
        .o_alu_op    (w_dec_alu_op)
    );

    // Last allowed wait cycle of a request.
    assign w_to_hit = (r_cnt == TO_W'(MEM_TIMEOUT - 1));

    // Next-state and control decode.
    always_comb begin
        w_next       = r_state;
        w_mem_req    = 1'b0;
        w_mem_write  = 1'b0;
        w_addr_sel   = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_pc_src     = 1'b0;
        w_alu_src    = 1'b0;
        w_alu_op     = '0;
        w_reg_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                if (bus.mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end else if (w_to_hit) begin
                    w_next = S_FAULT;
                end
            end
            S_DECODE: w_next = S_EXECUTE;
            S_EXECUTE: begin
                w_alu_src = w_dec_alu_src;
                w_alu_op  = w_dec_alu_op;
                if (w_is_rtype || w_is_itype) begin
                    w_next = S_WRITEBACK;
                end else if (w_is_load || w_is_store) begin
                    w_next = S_MEM;
                end else begin
                    // Branch resolves here; other S-type funct2 values are no-ops.
                    w_pc_write = w_is_branch && bus.branch_taken;
                    w_pc_src   = w_is_branch && bus.branch_taken;
                    w_next     = S_FETCH;
                end
            end
            S_MEM: begin
                w_mem_req   = 1'b1;
                w_addr_sel  = 1'b1;
                w_mem_write = w_is_store;
                w_alu_src   = w_dec_alu_src;
                w_alu_op    = w_dec_alu_op;
                if (bus.mem_ready) begin
                    w_next = w_is_load ? S_WRITEBACK : S_FETCH;
                end else if (w_to_hit) begin
                    w_next = S_FAULT;
                end
            end
            S_WRITEBACK: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = w_is_load;
                w_next       = S_FETCH;
            end
            S_FAULT: w_next = S_FAULT;
            default: w_next = S_FAULT;
        endcase
    end

    // State, latched instruction class, watchdog counter and sticky fault.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_FETCH;
            r_opcode <= '0;
            r_funct2 <= '0;
            r_cnt    <= '0;
            r_fault  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_ir_write) begin
                r_opcode <= bus.instr_in[1:0];
                r_funct2 <= bus.instr_in[7:6];
            end
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if ((r_state == S_FETCH || r_state == S_MEM) && !bus.mem_ready) begin
                r_cnt <= r_cnt + TO_W'(1);
            end
            if (w_next == S_FAULT) begin
                r_fault <= 1'b1;
            end
        end
    end

    // Reset forces every output low immediately.
    assign bus.mem_req    = w_mem_req    & ~rst;
    assign bus.mem_write  = w_mem_write  & ~rst;
    assign bus.addr_sel   = w_addr_sel   & ~rst;
    assign bus.ir_write   = w_ir_write   & ~rst;
    assign bus.pc_write   = w_pc_write   & ~rst;
    assign bus.pc_src     = w_pc_src     & ~rst;
    assign bus.alu_src    = w_alu_src    & ~rst;
    assign bus.alu_op     = rst ? '0 : w_alu_op;
    assign bus.reg_write  = w_reg_write  & ~rst;
    assign bus.mem_to_reg = w_mem_to_reg & ~rst;
    assign bus.fault      = r_fault      & ~rst;
    assign bus.state      = rst ? '0 : STATE_W'(r_state);
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (MEM_TIMEOUT=4).
module tb_multicycle_control;
    logic clk;
    logic rst;

    multicycle_control_if #(.INSTR_W(16)) bus ();

    multicycle_control #(.INSTR_W(16), .MEM_TIMEOUT(4), .TO_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Control word: {req, wr, addr, ir, pcw, pcs, asrc, op[1:0], rw, m2r, flt}
    localparam logic [11:0] REQ  = 12'h800;
    localparam logic [11:0] WR   = 12'h400;
    localparam logic [11:0] ADDR = 12'h200;
    localparam logic [11:0] IR   = 12'h100;
    localparam logic [11:0] PCW  = 12'h080;
    localparam logic [11:0] PCS  = 12'h040;
    localparam logic [11:0] ASRC = 12'h020;
    localparam logic [11:0] OP1  = 12'h008;
    localparam logic [11:0] OP2  = 12'h010;
    localparam logic [11:0] OP3  = 12'h018;
    localparam logic [11:0] RW   = 12'h004;
    localparam logic [11:0] M2R  = 12'h002;
    localparam logic [11:0] FLT  = 12'h001;
    localparam logic [11:0] NONE = 12'h000;

    localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, W = 3'd4, X = 3'd5;

    typedef struct packed {
        logic        rst;
        logic        rdy;
        logic        bt;
        logic [15:0] instr;
        logic [2:0]  st;
        logic [11:0] ctrl;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_err    = 0;

    function automatic vec_t mk(input logic r, input logic rdy, input logic bt,
                                input logic [15:0] ins, input logic [2:0] st,
                                input logic [11:0] ctrl);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.bt = bt; v.instr = ins; v.st = st; v.ctrl = ctrl;
        return v;
    endfunction

    // Drive one cycle's inputs, check outputs mid-cycle, advance to next negedge.
    task automatic apply(input logic r, input logic rdy, input logic bt,
                         input logic [15:0] ins, input logic [2:0] st,
                         input logic [11:0] ctrl, input string tag, input int idx);
        logic [11:0] act;
        rst              = r;
        bus.mem_ready    = rdy;
        bus.branch_taken = bt;
        bus.instr_in     = ins;
        #1;
        act = {bus.mem_req, bus.mem_write, bus.addr_sel, bus.ir_write, bus.pc_write,
               bus.pc_src, bus.alu_src, bus.alu_op, bus.reg_write, bus.mem_to_reg,
               bus.fault};
        n_checks++;
        if (act !== ctrl || bus.state !== st) begin
            n_err++;
            $display("FAIL %s[%0d]: got state=%0d ctrl=%03h, expected state=%0d ctrl=%03h",
                     tag, idx, bus.state, act, st, ctrl);
        end
        @(negedge clk);
    endtask

    initial begin
        // Reset, then R / load / store / branches / wait-on-4th-cycle / I / S-noop.
        tbl.push_back(mk(1, 0, 0, 16'h0000, F, NONE));
        tbl.push_back(mk(1, 0, 0, 16'h0000, F, NONE));
        tbl.push_back(mk(0, 0, 0, 16'h0000, F, REQ));
        tbl.push_back(mk(0, 1, 0, 16'h0040, F, REQ | IR | PCW));
        tbl.push_back(mk(0, 0, 0, 16'h0000, D, NONE));
        tbl.push_back(mk(0, 0, 0, 16'h0000, E, OP1));
        tbl.push_back(mk(0, 0, 0, 16'h0000, W, RW));
        tbl.push_back(mk(0, 1, 0, 16'h0041, F, REQ | IR | PCW));
        tbl.push_back(mk(0, 0, 0, 16'h0000, D, NONE));
        tbl.push_back(mk(0, 0, 0, 16'h0000, E, ASRC));
        tbl.push_back(mk(0, 0, 0, 16'h0000, M, REQ | ADDR | ASRC));
        tbl.push_back(mk(0, 0, 0, 16'h0000, M, REQ | ADDR | ASRC));
        tbl.push_back(mk(0, 1, 0, 16'h0000, M, REQ | ADDR | ASRC));
        tbl.push_back(mk(0, 0, 0, 16'h0000, W, RW | M2R));
        tbl.push_back(mk(0, 1, 0, 16'h0002, F, REQ | IR | PCW));
        tbl.push_back(mk(0, 0, 0, 16'h0000, D, NONE));
        tbl.push_back(mk(0, 0, 0, 16'h0000, E, ASRC));
        tbl.push_back(mk(0, 1, 0, 16'h0000, M, REQ | WR | ADDR | ASRC));
        tbl.push_back(mk(0, 1, 0, 16'h0003, F, REQ | IR | PCW));
        tbl.push_back(mk(0, 0, 0, 16'h0000, D, NONE));
        tbl.push_back(mk(0, 0, 1, 16'h0000, E, PCW | PCS));
        tbl.push_back(mk(0, 1, 0, 16'h0003, F, REQ | IR | PCW));
        tbl.push_back(mk(0, 0, 1, 16'h0000, D, NONE));
        tbl.push_back(mk(0, 0, 0, 16'h0000, E, NONE));
        tbl.push_back(mk(0, 0, 0, 16'h00C0, F, REQ));
        tbl.push_back(mk(0, 0, 0, 16'h00C0, F, REQ));
        tbl.push_back(mk(0, 0, 0, 16'h00C0, F, REQ));
        tbl.push_back(mk(0, 1, 0, 16'h00C0, F, REQ | IR | PCW));
        tbl.push_back(mk(0, 1, 0, 16'h0000, D, NONE));
        tbl.push_back(mk(0, 0, 0, 16'h0000, E, OP3));
        tbl.push_back(mk(0, 0, 0, 16'h0000, W, RW));
        tbl.push_back(mk(0, 0, 0, 16'h0000, F, REQ));
        tbl.push_back(mk(0, 1, 0, 16'h0081, F, REQ | IR | PCW));
        tbl.push_back(mk(0, 0, 0, 16'h0000, D, NONE));
        tbl.push_back(mk(0, 0, 0, 16'h0000, E, ASRC | OP2));
        tbl.push_back(mk(0, 0, 0, 16'h0000, W, RW));
        tbl.push_back(mk(0, 0, 0, 16'h0000, F, REQ));
        tbl.push_back(mk(0, 1, 0, 16'h0042, F, REQ | IR | PCW));
        tbl.push_back(mk(0, 0, 0, 16'h0000, D, NONE));
        tbl.push_back(mk(0, 0, 0, 16'h0000, E, ASRC | OP1));
        tbl.push_back(mk(0, 0, 0, 16'h0000, F, REQ));

        foreach (tbl[i])
            apply(tbl[i].rst, tbl[i].rdy, tbl[i].bt, tbl[i].instr, tbl[i].st,
                  tbl[i].ctrl, "vec", i);

        // Timeout in FETCH: four request cycles, then a sticky FAULT.
        apply(1, 0, 0, 16'h0000, F, NONE, "to_rst", 0);
        for (int i = 0; i < 4; i++)
            apply(0, 0, 0, 16'h0040, F, REQ, "to_req", i);
        for (int i = 0; i < 20; i++)
            apply(0, (i % 3) == 0, 0, 16'h0040, X, FLT, "to_fault", i);
        apply(1, 1, 0, 16'h0040, F, NONE, "to_clr", 0);
        apply(0, 0, 0, 16'h0000, F, REQ, "to_fetch", 0);

        // Reset during a load's MEM wait: no writeback afterwards.
        apply(0, 1, 0, 16'h0041, F, REQ | IR | PCW, "mm_fetch", 0);
        apply(0, 0, 0, 16'h0000, D, NONE, "mm_dec", 0);
        apply(0, 0, 0, 16'h0000, E, ASRC, "mm_exe", 0);
        apply(0, 0, 0, 16'h0000, M, REQ | ADDR | ASRC, "mm_wait", 0);
        apply(1, 1, 0, 16'h0000, F, NONE, "mm_rst", 0);
        apply(0, 0, 0, 16'h0000, F, REQ, "mm_after", 0);
        apply(0, 0, 0, 16'h0000, F, REQ, "mm_after", 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
